// File: rtl/i2s_mic_rx_pkg.sv
// Shared constants and run-state encoding for the I2S microphone receiver
// and its clock generator.
package i2s_mic_rx_pkg;

    localparam int I2S_SLOT_BITS  = 32;
    localparam int I2S_FRAME_BITS = 64;
    localparam int MIC_DATA_BITS  = 24;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } run_state_t;

endpackage

// File: rtl/i2s_mic_rx_if.sv
// Pin-level I2S bus plus the sample output stream of the microphone receiver.
interface i2s_mic_rx_if #(
    parameter int DATA_WIDTH = 16
);

    logic                  i2s_sck;
    logic                  i2s_ws;
    logic                  i2s_sd;
    logic [DATA_WIDTH-1:0] sample_out;
    logic                  sample_valid;

    modport master (
        output i2s_sck,
        output i2s_ws,
        input  i2s_sd,
        output sample_out,
        output sample_valid
    );

    modport slave (
        input  i2s_sck,
        input  i2s_ws,
        output i2s_sd,
        input  sample_out,
        input  sample_valid
    );

endinterface

// File: rtl/i2s_clkgen.sv
// I2S master clock generator: SCK/WS from the system clock plus per-bit strobes.
// Frame boundaries are the only points where en is honoured.
module i2s_clkgen
    import i2s_mic_rx_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              en,
    output logic                              sck,
    output logic                              ws,
    output logic [$clog2(I2S_FRAME_BITS)-1:0] bit_cnt,
    output logic                              sck_fall,
    output logic                              cap_en
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(I2S_FRAME_BITS);

    run_state_t       state, state_next;
    logic [DIV_W-1:0] div_cnt, div_next;
    logic             sck_next, ws_next;
    logic [BIT_W-1:0] bit_next;
    logic             terminal;

    assign terminal = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            sck     <= 1'b0;
            ws      <= 1'b0;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            div_cnt <= div_next;
            sck     <= sck_next;
            ws      <= ws_next;
            bit_cnt <= bit_next;
        end
    end

    // The last clk of a high phase is both the capture point and the clk that drops SCK.
    always_comb begin
        state_next = state;
        div_next   = div_cnt;
        sck_next   = sck;
        ws_next    = ws;
        bit_next   = bit_cnt;
        sck_fall   = 1'b0;
        cap_en     = 1'b0;
        case (state)
            IDLE: begin
                div_next = '0;
                sck_next = 1'b0;
                ws_next  = 1'b0;
                bit_next = '0;
                if (en) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (terminal) begin
                    div_next = '0;
                    sck_next = !sck;
                    if (sck) begin
                        sck_fall = 1'b1;
                        cap_en   = 1'b1;
                        bit_next = bit_cnt + BIT_W'(1);
                        ws_next  = bit_next[BIT_W-1];
                        if (bit_cnt == BIT_W'(I2S_FRAME_BITS - 1) && !en) begin
                            state_next = IDLE;
                        end
                    end
                end else begin
                    div_next = div_cnt + DIV_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S master receiver for one MEMS microphone: synchronises SD, shifts the
// selected slot MSB first and emits one truncated sample per frame.
module i2s_mic_rx
    import i2s_mic_rx_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int CHANNEL    = 0
) (
    input logic          clk,
    input logic          reset,
    input logic          en,
    i2s_mic_rx_if.master bus
);

    localparam int BIT_W  = $clog2(I2S_FRAME_BITS);
    localparam int SLOT_W = $clog2(I2S_SLOT_BITS);

    logic                  sck, ws, sck_fall, cap_en;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  sd_meta, sd_sync;
    logic [SLOT_W-1:0]     slot_bit;
    logic                  in_slot, take_bit, last_bit, frame_end;
    logic [DATA_WIDTH-1:0] shift_reg, sample_reg;
    logic                  load_pending, valid_reg;

    i2s_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .sck      (sck),
        .ws       (ws),
        .bit_cnt  (bit_cnt),
        .sck_fall (sck_fall),
        .cap_en   (cap_en)
    );

    assign bus.i2s_sck      = sck;
    assign bus.i2s_ws       = ws;
    assign bus.sample_out   = sample_reg;
    assign bus.sample_valid = valid_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sd_meta <= 1'b0;
            sd_sync <= 1'b0;
        end else begin
            sd_meta <= bus.i2s_sd;
            sd_sync <= sd_meta;
        end
    end

    // Slot bit 0 is the I2S delay bit; bits past DATA_WIDTH are dropped unrounded.
    assign slot_bit  = bit_cnt[SLOT_W-1:0];
    assign in_slot   = (bit_cnt[BIT_W-1] == (CHANNEL != 0));
    assign take_bit  = cap_en && in_slot && (slot_bit != '0) &&
                       (slot_bit <= SLOT_W'(DATA_WIDTH));
    assign last_bit  = cap_en && in_slot && (slot_bit == SLOT_W'(DATA_WIDTH));
    assign frame_end = sck_fall && (bit_cnt == BIT_W'(I2S_FRAME_BITS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
        end else if (frame_end) begin
            shift_reg <= '0;
        end else if (take_bit) begin
            shift_reg <= DATA_WIDTH'({shift_reg, sd_sync});
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_pending <= 1'b0;
            valid_reg    <= 1'b0;
            sample_reg   <= '0;
        end else begin
            load_pending <= last_bit;
            valid_reg    <= load_pending;
            if (load_pending) begin
                sample_reg <= shift_reg;
            end
        end
    end

endmodule
